seg7_rank_decoder: RTL
======================

Name: seg7_rank_decoder

Overview:
- Receives a 7-segment pattern on asynchronous segment lines and recovers the 4-bit card rank, i.e. the inverse of the team's rank-to-7-seg display encoding.
- Synchronises and debounces the lines, then decodes each new stable pattern.
- Presents each decoded rank on a valid/ready interface to the game-logic FSM.
- Used to read card ranks driven by a second board's display header.

Parameters:
- STABLE_CYCLES, 1000: consecutive cycles a synchronised pattern must hold before it is accepted. Legal range is 2..2^20. Counter width is $clog2(STABLE_CYCLES).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- seg_in  input  7  segment lines, asynchronous, active-high ON; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g
- ready_in  input  1  consumer accepts rank_out this cycle
- valid_out  output  1  rank_out/error_out hold a decoded event
- rank_out  output  4  decoded rank: 0=blank, 1=Ace .. 13=King
- error_out  output  1  pattern was nonzero and not in the table
- overrun_out  output  1  one-cycle pulse when a pending undelivered event is overwritten

Behaviour:
- Reset (async, active-high) clears all state. Sync flops, candidate and last_committed are 7'h00; count is 0; FSM is IDLE.
- Output reset values: valid_out=0, rank_out=0, error_out=0, overrun_out=0.
- Synchroniser: two flops on seg_in. Only the second-stage output (seg_s) is used downstream.
- Filter:
  - If seg_s != candidate: candidate<=seg_s and count<=0.
  - Otherwise count increments, saturating at STABLE_CYCLES-1.
  - Commit fires for exactly one cycle on the edge where candidate==seg_s and count==STABLE_CYCLES-1, and only if candidate != last_committed. On commit, last_committed<=candidate.
  - A held pattern never re-commits. A glitch shorter than STABLE_CYCLES produces no event.
- Latency: valid_out is high after the (STABLE_CYCLES+3)th rising edge, counting from the first edge that samples a new, thereafter constant seg_in value.
- Decode table, seg {g..a} hex -> rank:
  - 77->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 27->7
  - 7F->8, 6F->9, 3F->10, 1F->11, 67->12, 76->13
  - 00->0 (blank, error 0)
  - Any other value -> rank 0, error 1
- Output FSM, states IDLE and PEND:
  - IDLE, on commit: load rank_out/error_out, valid_out<=1, go to PEND.
  - PEND: valid_out, rank_out and error_out are held stable until valid_out&&ready_in.
  - PEND, handshake with no commit: valid_out<=0 next cycle, go to IDLE. rank_out/error_out keep their last values.
  - PEND, handshake and commit in the same cycle: load new data, stay in PEND with no bubble, overrun_out=0.
  - PEND, commit without ready_in: overwrite rank_out/error_out with the newest event, pulse overrun_out for 1 cycle, stay in PEND.
- ready_in is ignored in IDLE.
- Reset mid-filter or mid-PEND: immediately returns to the reset state. The pending event is discarded. The next stable pattern is compared against 7'h00.
- Startup with a blank display produces no event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (STABLE_CYCLES=4):
- Reset, then seg_in=7'h77 held, ready_in=1 -> valid_out rises after edge 7 with rank_out=1, error_out=0, high for 1 cycle; no further events while held.
- seg_in 7'h00 -> 7'h7F pulsed for 3 cycles -> 7'h00 -> no valid_out. Then 7'h76 held -> rank_out=13.
- ready_in=0; seg_in 7'h5B held, then 7'h4F held -> first event rank 2 pending; at second commit rank_out becomes 3 and overrun_out pulses once. Raise ready_in -> one handshake, valid_out drops next cycle.
- seg_in=7'h01 held -> valid_out with rank_out=0, error_out=1. Then 7'h00 held -> blank event with rank 0, error 0.
- 7'h1F accepted, then 7'h00, then 7'h1F again -> three events with ranks 11, 0, 11.
- Assert rst_in asynchronously mid-count and again while PEND -> all outputs 0 immediately; re-holding the same pattern after release produces a fresh event at full latency.

Source files
------------

// File: rtl/seg7_rank_decoder.sv
// Recovers a card rank from an asynchronous 7-segment pattern: two-flop sync,
// stability filter with one-shot commit, decode, and a valid/ready output stage.
module seg7_rank_decoder #(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] seg_in,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [3:0] rank_out,
    output logic       error_out,
    output logic       overrun_out
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, PEND} state_t;

    logic [6:0]    r_sync1, r_seg_s, r_cand, r_last;
    logic [CW-1:0] r_count;
    state_t        r_state, w_state_nx;
    logic          r_valid, r_err, r_ovr;
    logic [3:0]    r_rank;
    logic          w_valid_nx, w_err_nx, w_ovr_nx, w_commit, w_dec_err;
    logic [3:0]    w_rank_nx, w_dec_rank;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync1 <= 7'h00;
            r_seg_s <= 7'h00;
        end else begin
            r_sync1 <= seg_in;
            r_seg_s <= r_sync1;
        end
    end

    // Commit once per new stable pattern; a held pattern matches r_last and stays quiet.
    assign w_commit = (r_seg_s == r_cand) && (r_count == CMAX) && (r_cand != r_last);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cand  <= 7'h00;
            r_count <= '0;
            r_last  <= 7'h00;
        end else begin
            if (r_seg_s != r_cand) begin
                r_cand  <= r_seg_s;
                r_count <= '0;
            end else if (r_count != CMAX) begin
                r_count <= r_count + CW'(1);
            end
            if (w_commit) r_last <= r_cand;
        end
    end

    always_comb begin
        w_dec_rank = 4'd0;
        w_dec_err  = 1'b0;
        case (r_cand)
            7'h77:   w_dec_rank = 4'd1;
            7'h5B:   w_dec_rank = 4'd2;
            7'h4F:   w_dec_rank = 4'd3;
            7'h66:   w_dec_rank = 4'd4;
            7'h6D:   w_dec_rank = 4'd5;
            7'h7D:   w_dec_rank = 4'd6;
            7'h27:   w_dec_rank = 4'd7;
            7'h7F:   w_dec_rank = 4'd8;
            7'h6F:   w_dec_rank = 4'd9;
            7'h3F:   w_dec_rank = 4'd10;
            7'h1F:   w_dec_rank = 4'd11;
            7'h67:   w_dec_rank = 4'd12;
            7'h76:   w_dec_rank = 4'd13;
            7'h00:   w_dec_rank = 4'd0;
            default: w_dec_err  = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_valid_nx = r_valid;
        w_rank_nx  = r_rank;
        w_err_nx   = r_err;
        w_ovr_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_commit) begin
                    w_valid_nx = 1'b1;
                    w_rank_nx  = w_dec_rank;
                    w_err_nx   = w_dec_err;
                    w_state_nx = PEND;
                end
            end
            PEND: begin
                // New event always wins; it only counts as an overrun if the old one was not taken.
                if (w_commit) begin
                    w_rank_nx = w_dec_rank;
                    w_err_nx  = w_dec_err;
                    w_ovr_nx  = !ready_in;
                end else if (ready_in) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_rank  <= 4'd0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_valid <= w_valid_nx;
            r_rank  <= w_rank_nx;
            r_err   <= w_err_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    assign valid_out   = r_valid;
    assign rank_out    = r_rank;
    assign error_out   = r_err;
    assign overrun_out = r_ovr;
endmodule
